// File: rtl/mux_scan_ctrl_if.sv
// Scan sequencer bundle: scan control, mux select/sample
// and scan results.
interface mux_scan_ctrl_if;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [15:0] ch_mask;
    logic        mux_in;
    logic [3:0]  mux_sel;
    logic        busy;
    logic        done;
    logic [15:0] snapshot;
    logic [7:0]  scan_count;

    modport master (
        output start, abort, continuous, ch_mask, mux_in,
        input  mux_sel, busy, done, snapshot, scan_count
    );

    modport slave (
        input  start, abort, continuous, ch_mask, mux_in,
        output mux_sel, busy, done, snapshot, scan_count
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 mux select over the enabled channels, samples
// each after SETTLE cycles and publishes a 16-bit snapshot.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input logic           clk,
    input logic           rst_n,
    mux_scan_ctrl_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [3:0] SET  = 4'(SETTLE);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("mux_scan_ctrl: SETTLE must be 1..15");
        end
    endgenerate

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  sel;
    logic [15:0] mask;
    logic [15:0] shadow;
    logic [15:0] snap;
    logic [7:0]  count;
    logic        done_q;

    logic [15:0] above;
    logic [15:0] new_shadow;
    logic [4:0]  nxt;
    logic [4:0]  lo;

    // {found, index} of the lowest set bit
    function automatic logic [4:0] first_set(input logic [15:0] v);
        first_set = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) first_set = {1'b1, 4'(i)};
        end
    endfunction

    always_comb begin
        above      = mask & ~((16'd2 << sel) - 16'd1);
        nxt        = first_set(above);
        lo         = first_set(bus.ch_mask);
        new_shadow = shadow;
        new_shadow[sel] = bus.mux_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            sel    <= 4'd0;
            mask   <= 16'd0;
            shadow <= 16'd0;
            snap   <= 16'd0;
            count  <= 8'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.abort && bus.start && |bus.ch_mask) begin
                        mask   <= bus.ch_mask;
                        shadow <= 16'd0;
                        sel    <= lo[3:0];
                        cnt    <= SET;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (cnt != 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else if (nxt[4]) begin
                        shadow <= new_shadow;
                        sel    <= nxt[3:0];
                        cnt    <= SET;
                    end else begin
                        snap   <= new_shadow;
                        done_q <= 1'b1;
                        count  <= count + 8'd1;
                        // back-to-back restart keeps busy high
                        if (bus.continuous && |bus.ch_mask) begin
                            mask   <= bus.ch_mask;
                            shadow <= 16'd0;
                            sel    <= lo[3:0];
                            cnt    <= SET;
                        end else begin
                            shadow <= new_shadow;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mux_sel    = sel;
    assign bus.busy       = (state == WAIT);
    assign bus.done       = done_q;
    assign bus.snapshot   = snap;
    assign bus.scan_count = count;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: SETTLE=1 and SETTLE=3 instances
// against a per-cycle select-plan model.
module tb_mux_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [15:0] ch_mask;
    logic [15:0] pattern;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h",
                         name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S = (g == 0) ? 1 : 3;

        mux_scan_ctrl_if bus ();

        assign bus.start      = start;
        assign bus.abort      = abort;
        assign bus.continuous = continuous;
        assign bus.ch_mask    = ch_mask;
        assign bus.mux_in     = pattern[bus.mux_sel];

        mux_scan_ctrl #(.SETTLE(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Model: one queue entry per cycle the select is held.
        logic        m_busy;
        logic        m_done;
        logic [3:0]  m_sel;
        logic [15:0] m_snap;
        logic [15:0] m_sh;
        logic [7:0]  m_cnt;
        int          plan[$];

        task automatic build(input logic [15:0] msk);
            plan.delete();
            for (int c = 0; c < 16; c++)
                if (msk[c])
                    for (int r = 0; r < S; r++)
                        plan.push_back(c);
        endtask

        initial begin
            int ch;
            m_busy = 0; m_done = 0; m_sel = 0;
            m_snap = 0; m_sh = 0; m_cnt = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_busy = 0; m_done = 0; m_sel = 0;
                    m_snap = 0; m_sh = 0; m_cnt = 0;
                    plan.delete();
                end else begin
                    m_done = 0;
                    if (!m_busy) begin
                        if (!abort && start && ch_mask != 0) begin
                            build(ch_mask);
                            m_sh   = 0;
                            m_busy = 1;
                            m_sel  = 4'(plan[0]);
                        end
                    end else if (abort) begin
                        m_busy = 0;
                        plan.delete();
                    end else begin
                        ch = plan.pop_front();
                        if (plan.size() == 0 || plan[0] != ch)
                            m_sh[ch] = pattern[ch];
                        if (plan.size() == 0) begin
                            m_snap = m_sh;
                            m_done = 1;
                            m_cnt  = m_cnt + 8'd1;
                            if (continuous && ch_mask != 0) begin
                                build(ch_mask);
                                m_sh  = 0;
                                m_sel = 4'(plan[0]);
                            end else begin
                                m_busy = 0;
                            end
                        end else begin
                            m_sel = 4'(plan[0]);
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                check($sformatf("s%0d.busy", S),
                      16'(bus.busy), 16'(m_busy));
                check($sformatf("s%0d.done", S),
                      16'(bus.done), 16'(m_done));
                check($sformatf("s%0d.mux_sel", S),
                      16'(bus.mux_sel), 16'(m_sel));
                check($sformatf("s%0d.snapshot", S),
                      bus.snapshot, m_snap);
                check($sformatf("s%0d.scan_count", S),
                      16'(bus.scan_count), 16'(m_cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        logic [31:0] rv;
        int r;
        rv = $urandom;
        r  = $urandom_range(0, 3);
        if (r == 0)      ch_mask = 16'd0;
        else if (r == 1) ch_mask = 16'd1 << rv[19:16];
        else             ch_mask = rv[15:0];
        start   = ($urandom_range(0, 3) == 0);
        abort   = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) continuous = ~continuous;
        rv      = $urandom;
        pattern = rv[15:0];
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; continuous = 0;
        ch_mask = 0; pattern = 0;
        step();
        check("rst.busy", 16'(g_inst[0].bus.busy), 16'd0);
        check("rst.snapshot", g_inst[0].bus.snapshot, 16'd0);
        check("rst.count", 16'(g_inst[0].bus.scan_count), 16'd0);
        step();
        rst_n = 1;
        step();

        // full scan, pattern A5C3
        pattern = 16'hA5C3; ch_mask = 16'hFFFF; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c <= 16)
                check("d1.sel", 16'(g_inst[0].bus.mux_sel),
                      16'(c - 1));
            check("d1.done", 16'(g_inst[0].bus.done),
                  16'(c == 17));
            if (c == 17) begin
                check("d1.snap", g_inst[0].bus.snapshot, 16'hA5C3);
                check("d1.count",
                      16'(g_inst[0].bus.scan_count), 16'd1);
                check("d1.busy", 16'(g_inst[0].bus.busy), 16'd0);
            end
            step();
        end
        repeat (31) step();
        @(negedge clk);
        check("d1.s3.done", 16'(g_inst[1].bus.done), 16'd1);
        check("d1.s3.snap", g_inst[1].bus.snapshot, 16'hA5C3);
        step();

        // channels 0 and 15 only
        pattern = 16'hFFFF; ch_mask = 16'h8001; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 6)
                check("d2.sel", 16'(g_inst[1].bus.mux_sel),
                      (c <= 3) ? 16'd0 : 16'd15);
            check("d2.done", 16'(g_inst[1].bus.done),
                  16'(c == 7));
            check("d2.s1.done", 16'(g_inst[0].bus.done),
                  16'(c == 3));
            if (c == 7)
                check("d2.snap", g_inst[1].bus.snapshot, 16'h8001);
            step();
        end
        repeat (3) step();

        // empty mask start is ignored
        ch_mask = 16'h0000; start = 1;
        step();
        start = 0;
        repeat (3) begin
            @(negedge clk);
            check("m0.busy", 16'(g_inst[0].bus.busy), 16'd0);
            check("m0.count",
                  16'(g_inst[0].bus.scan_count), 16'd2);
            step();
        end

        // abort together with start in IDLE
        ch_mask = 16'hFFFF; start = 1; abort = 1;
        step();
        start = 0; abort = 0;
        @(negedge clk);
        check("abst.busy", 16'(g_inst[0].bus.busy), 16'd0);
        step();

        // abort in cycle 5
        start = 1;
        step();
        start = 0;
        repeat (4) step();
        abort = 1;
        step();
        abort = 0;
        @(negedge clk);
        check("ab.busy", 16'(g_inst[0].bus.busy), 16'd0);
        check("ab.s3.busy", 16'(g_inst[1].bus.busy), 16'd0);
        check("ab.snap", g_inst[0].bus.snapshot, 16'h8001);
        check("ab.count", 16'(g_inst[0].bus.scan_count), 16'd2);
        repeat (4) step();

        // mask change and start pulse mid-scan
        ch_mask = 16'h00F0; start = 1;
        step();
        start = 0;
        step();
        ch_mask = 16'hFFFF; start = 1;
        step();
        start = 0;
        repeat (20) step();
        check("mm.snap", g_inst[0].bus.snapshot, 16'h00F0);
        check("mm.s3.snap", g_inst[1].bus.snapshot, 16'h00F0);
        check("mm.count", 16'(g_inst[0].bus.scan_count), 16'd3);

        // continuous, wraps scan_count
        pattern = 16'h0002; ch_mask = 16'h0003;
        continuous = 1; start = 1;
        step();
        start = 0;
        repeat (520) step();
        continuous = 0;
        repeat (10) step();
        check("ct.count", 16'(g_inst[0].bus.scan_count), 16'd8);
        check("ct.s3.count",
              16'(g_inst[1].bus.scan_count), 16'd90);
        check("ct.busy", 16'(g_inst[0].bus.busy), 16'd0);
        check("ct.snap", g_inst[0].bus.snapshot, 16'h0002);

        // asynchronous reset mid-scan
        ch_mask = 16'hFFFF; start = 1;
        step();
        start = 0;
        repeat (3) step();
        #2 rst_n = 0;
        #1;
        check("ar.busy", 16'(g_inst[0].bus.busy), 16'd0);
        check("ar.done", 16'(g_inst[0].bus.done), 16'd0);
        check("ar.sel", 16'(g_inst[0].bus.mux_sel), 16'd0);
        check("ar.snap", g_inst[0].bus.snapshot, 16'd0);
        check("ar.count",
              16'(g_inst[0].bus.scan_count), 16'd0);
        check("ar.s3.busy", 16'(g_inst[1].bus.busy), 16'd0);
        check("ar.s3.sel", 16'(g_inst[1].bus.mux_sel), 16'd0);
        step();
        rst_n = 1;
        step();
        pattern = 16'h3C5A; ch_mask = 16'h0F00; start = 1;
        step();
        start = 0;
        repeat (20) step();
        check("ar.after.snap", g_inst[0].bus.snapshot, 16'h0C00);
        check("ar.after.count",
              16'(g_inst[0].bus.scan_count), 16'd1);

        // randomized traffic
        repeat (3000) begin
            rand_inputs();
            step();
        end
        start = 0; abort = 0; continuous = 0;
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
